// File: rtl/dma_burst_checker.sv
// AXI4 burst master that writes an incrementing pattern in INCR bursts, reads it
// back and counts data, response and RLAST errors in a saturating counter.
module dma_burst_checker #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    BURST_LEN   = 16,
   parameter int                    NUM_BURSTS  = 4,
   parameter logic [ADDR_WIDTH-1:0] TARGET_BASE = ADDR_WIDTH'(32'h4000_0000)
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      INIT_AXI_TXN,
   input  logic [1:0]                MODE,
   output logic                      TXN_DONE,
   output logic                      ERROR,
   output logic [15:0]               ERR_COUNT,
   output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [7:0]                M_AXI_AWLEN,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                      M_AXI_WLAST,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [7:0]                M_AXI_ARLEN,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RLAST,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY
);

   localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);
   localparam logic [10:0]           LAST_BURST  = 11'(NUM_BURSTS - 1);
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
   } state_t;

   state_t                  state_q;
   logic                    init_q;
   logic [1:0]              mode_q;
   logic [10:0]             burst_q;
   logic [8:0]              beat_q;
   logic [19:0]             gcnt_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
   logic                    txn_done_q;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic [1:0]              err_inc;
   logic [16:0]             err_sum;
   logic                    start;
   logic [DATA_WIDTH-1:0]   pat_cur, pat_next;

   assign start    = INIT_AXI_TXN & ~init_q & ((state_q == S_IDLE) | (state_q == S_DONE));
   // gcnt_q is the global beat index; the pattern value is index+1
   assign pat_cur  = DATA_WIDTH'(gcnt_q + 20'd1);
   assign pat_next = DATA_WIDTH'(gcnt_q + 20'd2);

   always_comb begin
      err_inc = 2'd0;
      if (state_q == S_WR_RESP && M_AXI_BVALID && M_AXI_BRESP != 2'b00)
         err_inc = 2'd1;
      if (state_q == S_RD_DATA && M_AXI_RVALID)
         err_inc = 2'({1'b0, M_AXI_RDATA != pat_cur}
                    + {1'b0, M_AXI_RRESP != 2'b00}
                    + {1'b0, M_AXI_RLAST != (beat_q == LAST_BEAT)});
      err_sum   = {1'b0, err_cnt_q} + 17'(err_inc);
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         init_q     <= 1'b0;
         mode_q     <= 2'b00;
         burst_q    <= '0;
         beat_q     <= '0;
         gcnt_q     <= '0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wlast_q    <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         txn_done_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         init_q    <= INIT_AXI_TXN;
         err_cnt_q <= err_cnt_d;
         if (start) begin
            mode_q     <= MODE;
            err_cnt_q  <= '0;
            txn_done_q <= 1'b0;
            burst_q    <= '0;
            beat_q     <= '0;
            gcnt_q     <= '0;
            if (MODE == 2'b10) begin
               state_q   <= S_RD_ADDR;
               arvalid_q <= 1'b1;
               araddr_q  <= TARGET_BASE;
            end else begin
               state_q   <= S_WR_ADDR;
               awvalid_q <= 1'b1;
               awaddr_q  <= TARGET_BASE;
            end
         end else begin
            case (state_q)
               S_WR_ADDR: if (M_AXI_AWREADY) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  wdata_q   <= pat_cur;
                  wlast_q   <= (beat_q == LAST_BEAT);
                  state_q   <= S_WR_DATA;
               end
               S_WR_DATA: if (M_AXI_WREADY) begin
                  gcnt_q <= gcnt_q + 20'd1;
                  if (wlast_q) begin
                     wvalid_q <= 1'b0;
                     beat_q   <= '0;
                     bready_q <= 1'b1;
                     state_q  <= S_WR_RESP;
                  end else begin
                     beat_q  <= beat_q + 9'd1;
                     wdata_q <= pat_next;
                     wlast_q <= (beat_q + 9'd1 == LAST_BEAT);
                  end
               end
               S_WR_RESP: if (M_AXI_BVALID) begin
                  bready_q <= 1'b0;
                  if (burst_q == LAST_BURST) begin
                     burst_q <= '0;
                     gcnt_q  <= '0;
                     if (mode_q == 2'b01) begin
                        state_q    <= S_DONE;
                        txn_done_q <= 1'b1;
                     end else begin
                        state_q   <= S_RD_ADDR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= TARGET_BASE;
                     end
                  end else begin
                     burst_q   <= burst_q + 11'd1;
                     awaddr_q  <= awaddr_q + BURST_BYTES;
                     awvalid_q <= 1'b1;
                     state_q   <= S_WR_ADDR;
                  end
               end
               S_RD_ADDR: if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_DATA;
               end
               // the burst ends on its BURST_LEN-th beat whatever RLAST says
               S_RD_DATA: if (M_AXI_RVALID) begin
                  gcnt_q <= gcnt_q + 20'd1;
                  if (beat_q == LAST_BEAT) begin
                     beat_q   <= '0;
                     rready_q <= 1'b0;
                     if (burst_q == LAST_BURST) begin
                        state_q    <= S_DONE;
                        txn_done_q <= 1'b1;
                     end else begin
                        burst_q   <= burst_q + 11'd1;
                        araddr_q  <= araddr_q + BURST_BYTES;
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_ADDR;
                     end
                  end else begin
                     beat_q <= beat_q + 9'd1;
                  end
               end
               S_IDLE, S_DONE: ;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign TXN_DONE      = txn_done_q;
   assign ERR_COUNT     = err_cnt_q;
   assign ERROR         = (err_cnt_q != 16'd0);
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WLAST   = wlast_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule
